// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a pending-write scoreboard.
//
// Registers are XLEN bits wide and NREG deep, with register 0 hard-wired
// to zero. There are two write ports. w0 is the primary ALU writeback port.
// w1 is the long-latency load/MUL writeback port. When both write the same
// register in one cycle, w0 wins.
//
// Each register also has a busy bit. sb_set marks a register busy when a
// long-latency operation issues. A w1 write retires it. When both happen in
// the same cycle, set wins.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   rp_addr  [NRP*AW]            read addresses, port k at [k*AW +: AW]
//   rp_data  [NRP*XLEN]          combinational read data (optionally forwarded)
//   rp_busy  [NRP]               busy bit of each read port's register
//   w0_we/w0_addr/w0_data        primary write port
//   w1_we/w1_addr/w1_data        secondary write port, also clears busy
//   sb_set/sb_addr               mark a register pending
//   busy_cnt [AW+1]              registered number of busy registers
//   dbg_addr/dbg_data            raw array read, never forwarded
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int NRP    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NRP*AW-1:0]    rp_addr,
   output logic [NRP*XLEN-1:0]  rp_data,
   output logic [NRP-1:0]       rp_busy,
   input  logic                 w0_we,
   input  logic [AW-1:0]        w0_addr,
   input  logic [XLEN-1:0]      w0_data,
   input  logic                 w1_we,
   input  logic [AW-1:0]        w1_addr,
   input  logic [XLEN-1:0]      w1_data,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_addr,
   output logic [AW:0]          busy_cnt,
   input  logic [AW-1:0]        dbg_addr,
   output logic [XLEN-1:0]      dbg_data
);

   localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic [AW:0]     busy_cnt_q;
   logic [AW:0]     busy_cnt_d;

   // Number of set bits in a busy vector.
   function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
      logic [AW:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) begin
         c = c + {{AW{1'b0}}, v[i]};
      end
      return c;
   endfunction

   // Next-state array: w1 is applied first so that a colliding w0 overwrites it.
   always_comb begin
      regs_d = regs_q;
      if (w1_we && (w1_addr != ZERO_ADDR)) begin
         regs_d[w1_addr] = w1_data;
      end else begin
         regs_d = regs_d;
      end
      if (w0_we && (w0_addr != ZERO_ADDR)) begin
         regs_d[w0_addr] = w0_data;
      end else begin
         regs_d = regs_d;
      end
   end

   // Next-state scoreboard: clear on w1 retire first, then set wins on collision.
   always_comb begin
      busy_d = busy_q;
      if (w1_we) begin
         busy_d[w1_addr] = 1'b0;
      end else begin
         busy_d = busy_d;
      end
      if (sb_set && (sb_addr != ZERO_ADDR)) begin
         busy_d[sb_addr] = 1'b1;
      end else begin
         busy_d = busy_d;
      end
      busy_d[0]  = 1'b0;
      busy_cnt_d = popcount(busy_d);
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         busy_cnt_q <= '0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         busy_cnt_q <= busy_cnt_d;
      end
   end

   for (genvar k = 0; k < NRP; k++) begin : g_rp
      logic [AW-1:0]   addr_s;
      logic [XLEN-1:0] data_s;
      logic            busy_s;

      assign addr_s = rp_addr[k*AW +: AW];

      // Read mux: zero register, then w0 forward, then w1 forward, then array.
      always_comb begin
         if (addr_s == ZERO_ADDR) begin
            data_s = '0;
         end else if ((BYPASS != 0) && w0_we && (w0_addr == addr_s)) begin
            data_s = w0_data;
         end else if ((BYPASS != 0) && w1_we && (w1_addr == addr_s)) begin
            data_s = w1_data;
         end else begin
            data_s = regs_q[addr_s];
         end
      end

      // Busy view: a w1 retiring this register in the current cycle hides it when forwarding.
      always_comb begin
         if (addr_s == ZERO_ADDR) begin
            busy_s = 1'b0;
         end else if ((BYPASS != 0) && w1_we && (w1_addr == addr_s)) begin
            busy_s = 1'b0;
         end else begin
            busy_s = busy_q[addr_s];
         end
      end

      assign rp_data[k*XLEN +: XLEN] = data_s;
      assign rp_busy[k]              = busy_s;
   end

   assign busy_cnt = busy_cnt_q;
   assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one forwarding instance and one non-forwarding
// instance share all inputs. Expected values come from a directed table and
// from a register/busy array model.
module tb_regfile_sb;

   localparam int XLEN = 32;
   localparam int NREG = 32;
   localparam int NRP  = 2;
   localparam int AW   = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [NRP*AW-1:0] rp_addr = '0;
   logic [AW-1:0]     ra0, ra1;
   logic              w0_we = 1'b0, w1_we = 1'b0, sb_set = 1'b0;
   logic [AW-1:0]     w0_addr = '0, w1_addr = '0, sb_addr = '0, dbg_addr = '0;
   logic [XLEN-1:0]   w0_data = '0, w1_data = '0;

   logic [NRP*XLEN-1:0] rp_data, rp_data_nb;
   logic [NRP-1:0]      rp_busy, rp_busy_nb;
   logic [AW:0]         busy_cnt, busy_cnt_nb;
   logic [XLEN-1:0]     dbg_data, dbg_data_nb;

   int n_vec = 0;
   int n_bad = 0;

   logic [XLEN-1:0] m_regs [NREG];
   logic            m_busy [NREG];

   assign ra0 = rp_addr[0 +: AW];
   assign ra1 = rp_addr[AW +: AW];

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) dut (
      .clk(clk), .rst_n(rst_n), .rp_addr(rp_addr), .rp_data(rp_data), .rp_busy(rp_busy),
      .w0_we(w0_we), .w0_addr(w0_addr), .w0_data(w0_data),
      .w1_we(w1_we), .w1_addr(w1_addr), .w1_data(w1_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data));

   regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .rp_addr(rp_addr), .rp_data(rp_data_nb), .rp_busy(rp_busy_nb),
      .w0_we(w0_we), .w0_addr(w0_addr), .w0_data(w0_data),
      .w1_we(w1_we), .w1_addr(w1_addr), .w1_data(w1_data),
      .sb_set(sb_set), .sb_addr(sb_addr), .busy_cnt(busy_cnt_nb),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data_nb));

   always #5 clk = ~clk;

   typedef struct {
      logic            w0_we;
      logic [AW-1:0]   w0_a;
      logic [XLEN-1:0] w0_d;
      logic            w1_we;
      logic [AW-1:0]   w1_a;
      logic [XLEN-1:0] w1_d;
      logic            sb;
      logic [AW-1:0]   sb_a;
      logic [AW-1:0]   r0;
      logic [AW-1:0]   r1;
      logic [XLEN-1:0] e_d0;
      logic [XLEN-1:0] e_d1;
      logic [XLEN-1:0] e_nb1;
      logic [1:0]      e_busy;
      logic [AW:0]     e_cnt;
   } vec_t;

   vec_t tbl [17];

   task automatic cmp(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NREG; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
   endtask

   // Spec rules applied at a rising edge.
   task automatic model_edge();
      if (w1_we && w1_addr != 5'd0) m_regs[w1_addr] = w1_data;
      if (w0_we && w0_addr != 5'd0) m_regs[w0_addr] = w0_data;
      if (w1_we) m_busy[w1_addr] = 1'b0;
      if (sb_set && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
   endtask

   function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a, input bit byp);
      if (a == 5'd0) return '0;
      if (byp && w0_we && w0_addr == a) return w0_data;
      if (byp && w1_we && w1_addr == a) return w1_data;
      return m_regs[a];
   endfunction

   function automatic logic m_rbusy(input logic [AW-1:0] a, input bit byp);
      if (a == 5'd0) return 1'b0;
      if (byp && w1_we && w1_addr == a) return 1'b0;
      return m_busy[a];
   endfunction

   function automatic logic [AW:0] m_cnt();
      int c = 0;
      for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
      return c[AW:0];
   endfunction

   task automatic check_model();
      for (int k = 0; k < NRP; k++) begin
         logic [AW-1:0] a;
         a = rp_addr[k*AW +: AW];
         cmp($sformatf("rp_data%0d", k), rp_data[k*XLEN +: XLEN], m_read(a, 1'b1));
         cmp($sformatf("rp_data%0d_nb", k), rp_data_nb[k*XLEN +: XLEN], m_read(a, 1'b0));
         cmp($sformatf("rp_busy%0d", k), {31'd0, rp_busy[k]}, {31'd0, m_rbusy(a, 1'b1)});
         cmp($sformatf("rp_busy%0d_nb", k), {31'd0, rp_busy_nb[k]}, {31'd0, m_rbusy(a, 1'b0)});
      end
      cmp("busy_cnt", {26'd0, busy_cnt}, {26'd0, m_cnt()});
      cmp("busy_cnt_nb", {26'd0, busy_cnt_nb}, {26'd0, m_cnt()});
      cmp("dbg_data", dbg_data, m_regs[dbg_addr]);
      cmp("dbg_data_nb", dbg_data_nb, m_regs[dbg_addr]);
   endtask

   task automatic set_idle();
      w0_we = 1'b0; w1_we = 1'b0; sb_set = 1'b0;
      w0_addr = '0; w1_addr = '0; sb_addr = '0;
      w0_data = '0; w1_data = '0;
   endtask

   // Drive at negedge, check mid-low-phase, then let the model see the edge.
   task automatic finish_cycle();
      @(posedge clk);
      #1;
      if (rst_n) model_edge();
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[2]  = '{1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 6'd0};
      tbl[4]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 2'b00, 6'd0};
      tbl[5]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 5'd0, 5'd3, 5'd7, 32'h11, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 6'd0};
      tbl[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd3, 5'd0, 32'h11, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd9, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0, 32'h0, 2'b01, 6'd1};
      tbl[9]  = tbl[8];
      tbl[10] = tbl[8];
      tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 5'd9, 5'd9, 32'h55, 32'h55, 32'h0, 2'b00, 6'd1};
      tbl[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd9, 5'd0, 32'h55, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[13] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd4, 5'd0, 32'h0, 32'h0, 32'h0, 2'b00, 6'd0};
      tbl[14] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h66, 1'b1, 5'd4, 5'd4, 5'd0, 32'h66, 32'h0, 32'h0, 2'b00, 6'd1};
      tbl[15] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd4, 5'd0, 32'h66, 32'h0, 32'h0, 2'b01, 6'd1};
      tbl[16] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd4, 5'd0, 32'h66, 32'h0, 32'h0, 2'b01, 6'd1};

      // Reset state.
      model_reset();
      #1 rst_n = 1'b0;
      @(negedge clk);
      dbg_addr = 5'd5;
      #2;
      cmp("reset busy_cnt", {26'd0, busy_cnt}, 32'd0);
      cmp("reset dbg_data", dbg_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         w0_we = tbl[i].w0_we; w0_addr = tbl[i].w0_a; w0_data = tbl[i].w0_d;
         w1_we = tbl[i].w1_we; w1_addr = tbl[i].w1_a; w1_data = tbl[i].w1_d;
         sb_set = tbl[i].sb;   sb_addr = tbl[i].sb_a;
         rp_addr = {tbl[i].r1, tbl[i].r0};
         dbg_addr = tbl[i].r0;
         #2;
         cmp($sformatf("tbl%0d rp_data0", i), rp_data[0 +: XLEN], tbl[i].e_d0);
         cmp($sformatf("tbl%0d rp_data1", i), rp_data[XLEN +: XLEN], tbl[i].e_d1);
         cmp($sformatf("tbl%0d rp_data1_nb", i), rp_data_nb[XLEN +: XLEN], tbl[i].e_nb1);
         cmp($sformatf("tbl%0d rp_busy", i), {30'd0, rp_busy}, {30'd0, tbl[i].e_busy});
         cmp($sformatf("tbl%0d busy_cnt", i), {26'd0, busy_cnt}, {26'd0, tbl[i].e_cnt});
         check_model();
         finish_cycle();
      end

      // Mark r1..r3 busy and write r10, then reset asynchronously mid-cycle.
      set_idle();
      for (int r = 1; r <= 3; r++) begin
         sb_set = 1'b1; sb_addr = AW'(r);
         if (r == 3) begin
            w0_we = 1'b1; w0_addr = 5'd10; w0_data = 32'hFF;
         end
         #2 check_model();
         finish_cycle();
      end
      set_idle();
      rp_addr = {5'd1, 5'd10};
      dbg_addr = 5'd10;
      #2;
      cmp("pre-reset busy_cnt", {26'd0, busy_cnt}, 32'd4);
      cmp("pre-reset r10", rp_data[0 +: XLEN], 32'hFF);
      #1 rst_n = 1'b0;
      model_reset();
      #1;
      cmp("async busy_cnt", {26'd0, busy_cnt}, 32'd0);
      cmp("async rp_busy", {30'd0, rp_busy}, 32'd0);
      cmp("async r10", rp_data[0 +: XLEN], 32'd0);
      cmp("async dbg r10", dbg_data, 32'd0);
      @(negedge clk);
      // Writes and marks while in reset are ignored.
      w0_we = 1'b1; w0_addr = 5'd10; w0_data = 32'h77;
      w1_we = 1'b1; w1_addr = 5'd11; w1_data = 32'h88;
      sb_set = 1'b1; sb_addr = 5'd12;
      @(posedge clk);
      #1;
      cmp("in-reset busy_cnt", {26'd0, busy_cnt}, 32'd0);
      cmp("in-reset dbg r10", dbg_data, 32'd0);
      @(negedge clk);
      set_idle();
      rst_n = 1'b1;
      #2 check_model();
      finish_cycle();

      // Randomized traffic against the model; small address range for collisions.
      for (int n = 0; n < 400; n++) begin
         w0_we = 1'($urandom); w0_addr = AW'($urandom_range(0, 7)); w0_data = $urandom;
         w1_we = 1'($urandom); w1_addr = AW'($urandom_range(0, 7)); w1_data = $urandom;
         sb_set = 1'($urandom); sb_addr = AW'($urandom_range(0, 7));
         if (n % 50 == 25) begin
            w0_addr = AW'($urandom_range(0, 31));
            sb_addr = AW'($urandom_range(0, 31));
         end
         rp_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
         if (n % 7 == 0) rp_addr = {w1_addr, w0_addr};
         dbg_addr = AW'($urandom_range(0, 7));
         #2 check_model();
         finish_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
